mux_pipe: RTL and testbench

- Parametrised, pipelined successor to the 2:1 32-bit datapath mux.
- Selects one of NUM_IN WIDTH-bit channels and registers the result behind a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with no bubbles, and data is held stable under backpressure.
- Used where the MIPS datapath (writeback select, forwarding select) is split across a pipeline boundary.

---
 rtl/mux_pkg.sv | 32 +++
 rtl/mux_sel_comb.sv | 34 +++
 rtl/mux_pipe.sv | 139 +++++++++++++
 tb/tb_mux_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults, clog2 helper and buffer state encoding for mux_pipe
//
// No ports. Provides:
//   DEF_WIDTH, DEF_NUM_IN  default channel width and channel count
//   state_t                occupancy of the two-entry output buffer
//   clog2()                ceiling log2, used to size the select field
package mux_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 2;

  // EMPTY: nothing buffered; ONE: main register holds a beat;
  // FULL: main and skid both hold beats.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// rtl/mux_sel_comb.sv - combinational N:1 channel select with out-of-range flag
//
// Ports:
//   data  in   NUM_IN*WIDTH  packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel   in   SEL_W         channel select
//   y     out  WIDTH         selected channel, zero when sel is out of range
//   err   out  1             sel >= NUM_IN
module mux_sel_comb
  import mux_pkg::*;
#(
  parameter int   WIDTH  = DEF_WIDTH,
  parameter int   NUM_IN = DEF_NUM_IN,
  localparam int  SEL_W  = (clog2(NUM_IN) > 1) ? clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        y,
  output logic                    err
);

  // One extra bit so NUM_IN == 2**SEL_W is representable.
  localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_IN);

  always_comb begin
    y   = '0;
    err = ({1'b0, sel} >= LIMIT);
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        y = data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// rtl/mux_pipe.sv - pipelined N:1 datapath mux behind a two-entry skid buffer
//
// Ports:
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous active-high reset
//   in_data    in   NUM_IN*WIDTH  packed channels, channel k at [k*WIDTH +: WIDTH]
//   in_sel     in   SEL_W         channel select, sampled with in_data
//   in_valid   in   1             input beat valid
//   in_ready   out  1             registered; block can accept a beat
//   out_data   out  WIDTH         selected, registered data
//   out_sel    out  SEL_W         in_sel echoed with its data
//   out_err    out  1             in_sel was >= NUM_IN for this beat
//   out_valid  out  1             output beat valid
//   out_ready  in   1             downstream accepts
module mux_pipe
  import mux_pkg::*;
#(
  parameter int   WIDTH  = DEF_WIDTH,
  parameter int   NUM_IN = DEF_NUM_IN,
  localparam int  SEL_W  = (clog2(NUM_IN) > 1) ? clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  mux_sel_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .data (in_data),
    .sel  (in_sel),
    .y    (sel_data),
    .err  (sel_err)
  );

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_err;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // out_valid follows the state register, so it drops as soon as rst rises.
  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // in_ready is computed from the next state, so it never depends
  // combinationally on out_ready and stays low for the reset cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main_in) begin
        out_data <= sel_data;
        out_sel  <= in_sel;
        out_err  <= sel_err;
      end else if (load_main_skid) begin
        out_data <= skid_data;
        out_sel  <= skid_sel;
        out_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_sel  <= in_sel;
        skid_err  <= sel_err;
      end else if (load_main_skid) begin
        skid_data <= '0;
        skid_sel  <= '0;
        skid_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
// tb/tb_mux_pipe.sv - self-checking bench for mux_pipe (NUM_IN=2 and NUM_IN=5 instances)
module tb_mux_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [63:0]  in_data_a;
  logic         in_sel_a, in_valid_a, in_ready_a;
  logic [31:0]  out_data_a;
  logic         out_sel_a, out_err_a, out_valid_a, out_ready_a;

  logic [159:0] in_data_b;
  logic [2:0]   in_sel_b, out_sel_b;
  logic         in_valid_b, in_ready_b, out_err_b, out_valid_b, out_ready_b;
  logic [31:0]  out_data_b;

  int checks = 0;
  int errors = 0;

  mux_pipe #(.WIDTH(32), .NUM_IN(2)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_sel(in_sel_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_sel(out_sel_a), .out_err(out_err_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a)
  );

  mux_pipe #(.WIDTH(32), .NUM_IN(5)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_sel(in_sel_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_sel(out_sel_b), .out_err(out_err_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b)
  );

  // Reference model for instance a: a FIFO of at most two accepted beats,
  // each stored as {err, sel, data}. The head is what the output should show.
  logic [33:0] q_a[$];
  logic        rdy_en_a = 1'b0;

  function automatic logic [33:0] ref_a(input logic [63:0] d, input logic s);
    logic [63:0] t;
    t = d >> (32 * s);
    return {1'b0, s, t[31:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a.delete();
      rdy_en_a <= 1'b0;
    end else begin
      if (in_valid_a && rdy_en_a && q_a.size() < 2) begin
        if (out_ready_a && q_a.size() > 0) void'(q_a.pop_front());
        q_a.push_back(ref_a(in_data_a, in_sel_a));
      end else if (out_ready_a && q_a.size() > 0) begin
        void'(q_a.pop_front());
      end
      rdy_en_a <= 1'b1;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_a); end
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready_a); end
    checks++; if (out_data_a !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data_a); end
    checks++; if (out_sel_a !== 1'b0 || out_err_a !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b/%b exp 0/0", out_sel_a, out_err_a); end
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL reset_out_valid_b got %b exp 0", out_valid_b); end
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL reset_held_in_ready got %b exp 0", in_ready_a); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready_a); end
  endtask

  task automatic test_basic();
    out_ready_a = 1'b1;
    in_data_a   = {32'h12345678, 32'hDEADBEEF};
    in_sel_a    = 1'b0;
    in_valid_a  = 1'b1;
    @(negedge clk);
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid_a); end
    checks++; if (out_data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_ch0 got %h exp deadbeef", out_data_a); end
    checks++; if (out_err_a !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", out_err_a); end
    in_sel_a = 1'b1;
    @(negedge clk);
    checks++; if (out_data_a !== 32'h12345678 || out_sel_a !== 1'b1) begin errors++; $display("FAIL basic_ch1 got %h/%b exp 12345678/1", out_data_a, out_sel_a); end
    in_valid_a = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid_a); end
  endtask

  task automatic test_backpressure();
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    in_sel_a    = 1'b0;
    in_data_a   = {32'h0, 32'd1};
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b1 || out_data_a !== 32'd1) begin errors++; $display("FAIL bp_a got rdy %b data %h exp 1/1", in_ready_a, out_data_a); end
    in_data_a = {32'h0, 32'd2};
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b0 || out_data_a !== 32'd1) begin errors++; $display("FAIL bp_b got rdy %b data %h exp 0/1", in_ready_a, out_data_a); end
    in_data_a = {32'h0, 32'd3};
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b0 || out_data_a !== 32'd1) begin errors++; $display("FAIL bp_hold got rdy %b data %h exp 0/1", in_ready_a, out_data_a); end
    out_ready_a = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b1 || out_data_a !== 32'd2) begin errors++; $display("FAIL bp_out2 got rdy %b data %h exp 1/2", in_ready_a, out_data_a); end
    @(negedge clk);
    checks++; if (out_valid_a !== 1'b1 || out_data_a !== 32'd3) begin errors++; $display("FAIL bp_out3 got v %b data %h exp 1/3", out_valid_a, out_data_a); end
    in_valid_a = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid_a); end
  endtask

  task automatic test_err_sel();
    logic [31:0] ch[5];
    logic [2:0]  sels[4];
    logic [31:0] exp_d;
    logic        exp_e;
    sels[0] = 3'd6; sels[1] = 3'd4; sels[2] = 3'd5; sels[3] = 3'd0;
    for (int k = 0; k < 5; k++) begin
      ch[k] = $urandom;
      in_data_b[k*32 +: 32] = ch[k];
    end
    out_ready_b = 1'b1;
    in_valid_b  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel_b = sels[i];
      exp_e = (int'(sels[i]) >= 5);
      exp_d = exp_e ? 32'h0 : ch[sels[i]];
      @(negedge clk);
      checks++; if (out_valid_b !== 1'b1 || out_err_b !== exp_e || out_sel_b !== sels[i]) begin errors++; $display("FAIL err_flag sel %0d got v %b err %b sel %0d exp 1/%b/%0d", sels[i], out_valid_b, out_err_b, out_sel_b, exp_e, sels[i]); end
      checks++; if (out_data_b !== exp_d) begin errors++; $display("FAIL err_data sel %0d got %h exp %h", sels[i], out_data_b, exp_d); end
    end
    in_valid_b = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL err_drain got %b exp 0", out_valid_b); end
  endtask

  task automatic test_stream();
    int n_out;
    logic [33:0] exp_b;
    n_out = 0;
    out_ready_a = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data_a  = {$urandom, $urandom};
      in_sel_a   = 1'($urandom);
      in_valid_a = 1'b1;
      @(negedge clk);
      exp_b = (q_a.size() > 0) ? q_a[0] : 34'h0;
      if (out_valid_a === 1'b1) n_out++;
      checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL stream_bubble beat %0d got %b exp 1", i, out_valid_a); end
      checks++; if ({out_err_a, out_sel_a, out_data_a} !== exp_b) begin errors++; $display("FAIL stream_data beat %0d got %h exp %h", i, {out_err_a, out_sel_a, out_data_a}, exp_b); end
    end
    in_valid_a = 1'b0;
    @(negedge clk);
    checks++; if (n_out !== 100 || out_valid_a !== 1'b0) begin errors++; $display("FAIL stream_count got %0d v %b exp 100/0", n_out, out_valid_a); end
  endtask

  task automatic test_random();
    int n_in, n_out;
    logic stall;
    logic [33:0] snap, exp_b;
    n_in = 0; n_out = 0; stall = 1'b0; snap = '0;
    for (int i = 0; i < 1000; i++) begin
      checks++; if (out_valid_a !== (q_a.size() > 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", i, out_valid_a, q_a.size() > 0); end
      checks++; if (in_ready_a !== (rdy_en_a && q_a.size() < 2)) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", i, in_ready_a, rdy_en_a && q_a.size() < 2); end
      if (q_a.size() > 0) begin
        exp_b = q_a[0];
        checks++; if ({out_err_a, out_sel_a, out_data_a} !== exp_b) begin errors++; $display("FAIL rand_data cyc %0d got %h exp %h", i, {out_err_a, out_sel_a, out_data_a}, exp_b); end
      end
      if (stall) begin
        checks++; if ({out_err_a, out_sel_a, out_data_a} !== snap) begin errors++; $display("FAIL rand_stable cyc %0d got %h exp %h", i, {out_err_a, out_sel_a, out_data_a}, snap); end
      end
      in_valid_a  = ($urandom_range(0, 9) < 7);
      in_data_a   = {$urandom, $urandom};
      in_sel_a    = 1'($urandom);
      out_ready_a = 1'($urandom);
      stall = out_valid_a && !out_ready_a;
      snap  = {out_err_a, out_sel_a, out_data_a};
      if (in_valid_a && in_ready_a) n_in++;
      if (out_valid_a && out_ready_a) n_out++;
      @(negedge clk);
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (out_valid_a) n_out++;
      @(negedge clk);
    end
    checks++; if (n_in !== n_out || n_in == 0) begin errors++; $display("FAIL rand_conserve got in %0d out %0d exp equal nonzero", n_in, n_out); end
    checks++; if (out_valid_a !== 1'b0 || q_a.size() != 0) begin errors++; $display("FAIL rand_empty got v %b q %0d exp 0/0", out_valid_a, q_a.size()); end
  endtask

  task automatic test_reset_full();
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    in_sel_a    = 1'b0;
    in_data_a   = {32'h0, 32'hAAAA0001};
    @(negedge clk);
    in_data_a = {32'h0, 32'hAAAA0002};
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1) begin errors++; $display("FAIL rf_full got rdy %b v %b exp 0/1", in_ready_a, out_valid_a); end
    in_valid_a = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0) begin errors++; $display("FAIL rf_async got v %b rdy %b exp 0/0", out_valid_a, in_ready_a); end
    checks++; if (out_data_a !== 32'h0) begin errors++; $display("FAIL rf_data_clear got %h exp 0", out_data_a); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin errors++; $display("FAIL rf_release got rdy %b v %b exp 1/0", in_ready_a, out_valid_a); end
    out_ready_a = 1'b1;
    in_valid_a  = 1'b1;
    in_sel_a    = 1'b1;
    in_data_a   = {32'hCAFEF00D, 32'h1};
    @(negedge clk);
    checks++; if (out_valid_a !== 1'b1 || out_data_a !== 32'hCAFEF00D) begin errors++; $display("FAIL rf_first got v %b data %h exp 1/cafef00d", out_valid_a, out_data_a); end
    in_valid_a = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rf_no_stale got %b exp 0", out_valid_a); end
  endtask

  initial begin
    in_data_a = '0; in_sel_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
    in_data_b = '0; in_sel_b = 3'd0; in_valid_b = 1'b0; out_ready_b = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_err_sel();
    test_stream();
    test_random();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
